// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids,
// response codes and the default memory size.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int   NUM_PORTS     = 2;
  localparam logic PORT_CPU      = 1'b0;
  localparam logic PORT_HOST     = 1'b1;
  localparam logic DMEM_RSP_OK   = 1'b0;
  localparam logic DMEM_RSP_ERR  = 1'b1;
  localparam int   MEM_BYTES_DEF = 4096;

  // One-hot port vector for a port index.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic g);
    return (g == PORT_HOST) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational: on a tie the port that did
// not win last time gets the grant; otherwise the lone requester wins.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_grant,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 g
);

  // Winner index and gated one-hot grant.
  always_comb begin
    g     = PORT_CPU;
    grant = '0;
    if (req == 2'b11) g = ~last_grant;
    else              g = req[PORT_HOST];
    if (en && (|req)) grant = port_onehot(g);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store path (port 0)
// and the host loader (port 1). One transaction in flight, fixed read
// latency, out-of-range addresses answered with an error and no access.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MEM_BYTES    = MEM_BYTES_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic [NUM_PORTS-1:0] req_we,
  input  logic [ADDR_W-1:0]    req_addr0,
  input  logic [ADDR_W-1:0]    req_addr1,
  input  logic [DATA_W-1:0]    req_wdata0,
  input  logic [DATA_W-1:0]    req_wdata1,
  output logic [NUM_PORTS-1:0] req_ready,
  output logic [NUM_PORTS-1:0] rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy,
  output logic [31:0]          grant_cnt0,
  output logic [31:0]          grant_cnt1
);

  // Highest legal start address of a full-width access.
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 8);
  localparam logic [2:0]        LAT_LD   = 3'(READ_LATENCY - 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e                          state;
  req_t                            sel, req_q;
  logic                            sel_err;
  logic                            g_q, last_grant;
  logic [2:0]                      lat_cnt;
  logic [NUM_PORTS-1:0]            arb_grant;
  logic                            arb_g, arb_en;
  logic [NUM_PORTS-1:0][31:0]      gcnt;

  // Grants are only offered while idle and out of reset.
  assign arb_en = (state == ST_IDLE) && rst;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (arb_en),
    .grant      (arb_grant),
    .g          (arb_g)
  );

  assign req_ready  = arb_grant;
  assign busy       = (state != ST_IDLE);
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign grant_cnt0 = gcnt[PORT_CPU];
  assign grant_cnt1 = gcnt[PORT_HOST];

  // Payload mux for the winning port and its range check.
  always_comb begin
    sel.we    = req_we[arb_g];
    sel.addr  = (arb_g == PORT_HOST) ? req_addr1  : req_addr0;
    sel.wdata = (arb_g == PORT_HOST) ? req_wdata1 : req_wdata0;
    sel_err   = (sel.addr > ADDR_MAX);
  end

  // Transaction FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      g_q        <= PORT_CPU;
      last_grant <= PORT_HOST;
      lat_cnt    <= '0;
      rsp_valid  <= '0;
      rsp_err    <= DMEM_RSP_OK;
      rsp_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= DMEM_RSP_OK;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            g_q   <= arb_g;
            req_q <= sel;
            if (sel_err) begin
              // Out of range: answer straight away, never touch memory.
              state     <= ST_DONE;
              rsp_valid <= port_onehot(arb_g);
              rsp_err   <= DMEM_RSP_ERR;
              rsp_rdata <= '0;
            end else begin
              state  <= ST_ACCESS;
              mem_en <= 1'b1;
              mem_we <= sel.we;
            end
          end
        end
        ST_ACCESS: begin
          if (req_q.we) begin
            state     <= ST_DONE;
            rsp_valid <= port_onehot(g_q);
            rsp_rdata <= '0;
          end else begin
            state   <= ST_WAIT;
            lat_cnt <= LAT_LD;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 3'd0) begin
            state     <= ST_DONE;
            rsp_valid <= port_onehot(g_q);
            rsp_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          last_grant <= g_q;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating per-port accept counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (req_ready[p] && (gcnt[p] != 32'hFFFF_FFFF)) gcnt[p] <= gcnt[p] + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a 3-cycle read-latency memory model.
module tb_dmem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MB = 4096;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [AW-1:0] req_addr0, req_addr1, mem_addr;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, mem_wdata, mem_rdata;
  logic          rsp_err, mem_en, mem_we, busy;
  logic [31:0]   grant_cnt0, grant_cnt1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  int cyc = 0;
  int en_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en) en_cnt <= en_cnt + 1;

  // Memory model: read data appears RL cycles after the access cycle, one cycle wide.
  logic [63:0] tmem [512];
  logic [63:0] p0 = '0, p1 = '0, p2 = '0;
  initial for (int i = 0; i < 512; i++) tmem[i] = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) tmem[mem_addr[11:3]] <= mem_wdata;
    p0 <= (mem_en && !mem_we) ? tmem[mem_addr[11:3]] : 64'h0;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata = p2;

  typedef struct {
    logic [1:0]  vld;
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] v, input logic e, input logic [63:0] d, input int c);
    exp_t x;
    x.vld = v; x.err = e; x.rdata = d; x.cyc = c;
    sbq.push_back(x);
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t x;
    if (rsp_valid != 2'b00) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: actual rsp_valid=%b required none outstanding", rsp_valid);
      end else begin
        x = sbq.pop_front();
        chk("rsp_port",  rsp_valid, x.vld);
        chk("rsp_err",   rsp_err,   x.err);
        chk("rsp_rdata", rsp_rdata, x.rdata);
        chk("rsp_cycle", cyc,       x.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the DUT is idle and every expected response arrived.
  task automatic settle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sbq.size() != 0) && n < 30);
    if (n >= 30) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: actual busy=%0d pending=%0d required idle", tag, busy, sbq.size());
    end
  endtask

  // One request on a quiet bus with hand-computed response and latency.
  task automatic single(input string tag, input int p, input logic we, input logic [63:0] a,
                        input logic [63:0] d, input logic err, input logic [63:0] rd, input int lat);
    int c0, e0;
    logic [1:0] oh;
    oh = (p == 0) ? 2'b01 : 2'b10;
    step();
    req_we = we ? oh : 2'b00;
    if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
    req_valid = oh;
    c0 = cyc;
    e0 = en_cnt;
    expect_rsp(oh, err, rd, c0 + lat);
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, oh);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk({tag, "_mem_en"}, mem_en, !err);
    if (!err) begin
      chk({tag, "_mem_we"},    mem_we,    we);
      chk({tag, "_mem_addr"},  mem_addr,  a);
      chk({tag, "_mem_wdata"}, mem_wdata, d);
    end
    settle(tag);
    chk({tag, "_en_pulses"}, en_cnt - e0, err ? 0 : 1);
  endtask

  logic [1:0] ord [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int ngr, n, e0, c0;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;

    // Reset state, with requests present to show ready is held off.
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);
    step();
    req_valid = 2'b00;
    step();
    rst = 1'b1;

    // Directed single transactions.
    single("wr0",      0, 1'b1, 64'h10,   64'hDEADBEEF, 1'b0, 64'h0,        2);
    chk("wr0_cnt0", grant_cnt0, 1);
    single("rd1",      1, 1'b0, 64'h10,   64'h0,        1'b0, 64'hDEADBEEF, 5);
    single("err0",     0, 1'b0, 64'h1000, 64'h0,        1'b1, 64'h0,        1);
    single("err1",     1, 1'b1, 64'hFF9,  64'h77,       1'b1, 64'h0,        1);
    single("wr_edge",  0, 1'b1, 64'hFF8,  64'h1234,     1'b0, 64'h0,        2);
    single("rd_edge",  1, 1'b0, 64'hFF8,  64'h0,        1'b0, 64'h1234,     5);
    chk("cnt0_after", grant_cnt0, 3);
    chk("cnt1_after", grant_cnt1, 3);

    // Fairness: both ports request continuously after a fresh reset.
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    req_we = 2'b11;
    req_addr0 = 64'h100; req_wdata0 = 64'hA0;
    req_addr1 = 64'h200; req_wdata1 = 64'hB1;
    req_valid = 2'b11;
    ngr = 0;
    n = 0;
    while (ngr < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00) begin
        chk("fair_grant", req_ready, ord[ngr]);
        expect_rsp(ord[ngr], 1'b0, 64'h0, cyc + 2);
        ngr++;
      end
    end
    if (ngr < 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fair_timeout: actual grants=%0d required 4", ngr);
    end
    step();
    req_valid = 2'b00;
    settle("fair");
    chk("fair_cnt0", grant_cnt0, 2);
    chk("fair_cnt1", grant_cnt1, 2);

    // Reset while a port-1 read sits in WAIT: no response may ever appear.
    step();
    req_we = 2'b00;
    req_addr1 = 64'h10;
    req_valid = 2'b10;
    @(negedge clk);
    chk("abort_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 2'b00);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_cnt1", grant_cnt1, 0);
    chk("abort_mem_addr", mem_addr, 0);
    e0 = en_cnt;
    step();
    step();
    rst = 1'b1;
    repeat (8) step();
    chk("abort_no_access", en_cnt - e0, 0);

    // Tie after reset goes to port 0; port 1 withdraws during port 0's ACCESS.
    req_we = 2'b01;
    req_addr0 = 64'h20; req_wdata0 = 64'h55;
    req_addr1 = 64'h10;
    req_valid = 2'b11;
    c0 = cyc;
    expect_rsp(2'b01, 1'b0, 64'h0, c0 + 2);
    @(negedge clk);
    chk("tie_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("drop_busy_access", busy, 1);
    step();
    @(negedge clk);
    chk("drop_busy_done", busy, 1);
    step();
    @(negedge clk);
    chk("drop_busy_idle", busy, 0);
    repeat (3) begin
      step();
      @(negedge clk);
      chk("drop_ready", req_ready, 2'b00);
    end
    chk("drop_cnt0", grant_cnt0, 1);
    chk("drop_cnt1", grant_cnt1, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one single-port data memory between two requesters: port 0 is the CPU load/store path (AddressBus/DataBusOut/ControlBus side), port 1 is a debug/DMA host loader.
- Round-robin grant, one transaction in flight, fixed-latency read pipeline.
- Range-checks the address.
- Sits between the CPU bus and the data memory array; the CPU stalls its clock while its request is pending.

Parameters:
- ADDR_W, 64, address width (matches BIT_WIDTH).
- DATA_W, 64, data width.
- MEM_BYTES, 4096, memory size in bytes (matches MEMORY_SIZE); any address >= MEM_BYTES-7 is out of range.
- READ_LATENCY, 1, cycles from the memory access cycle to valid mem_rdata; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  2  per-port request valid.
- req_we  input  2  per-port write (1) / read (0).
- req_addr0, req_addr1  input  ADDR_W  per-port byte address.
- req_wdata0, req_wdata1  input  DATA_W  per-port write data.
- req_ready  output  2  per-port request accepted (one-hot or 0).
- rsp_valid  output  2  per-port response pulse (one-hot or 0).
- rsp_rdata  output  DATA_W  read data for the responding port.
- rsp_err  output  1  response is an out-of-range error.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  state != IDLE.
- grant_cnt0, grant_cnt1  output  32  per-port accepted-transaction counters, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; all outputs 0.
  - last_grant = 1, so port 0 wins the first tie.
  - grant_cnt0/1 = 0.
  - Reset mid-transaction aborts it: no rsp_valid, no mem_en after reset.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req_valid: select winner g. With both valid, g = ~last_grant; otherwise g = the valid port.
  - req_ready[g] = 1 combinationally in this cycle only.
  - Latch addr, wdata, we of port g; increment grant_cnt[g] (saturating at 0xFFFFFFFF).
  - If latched addr > MEM_BYTES-8: go to DONE with err=1 and no memory access. Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latched registers.
  - Write: next state DONE.
  - Read: load lat_cnt = READ_LATENCY-1, next state WAIT.
- WAIT:
  - If lat_cnt==0: capture mem_rdata into rsp_rdata, go to DONE. Otherwise decrement lat_cnt.
  - mem_en=0 throughout WAIT.
- DONE (1 cycle):
  - rsp_valid[g]=1; rsp_err=err.
  - rsp_rdata = captured data for reads; 0 for writes and errors.
  - last_grant <= g; next state IDLE.
  - No response backpressure.
- Outside the defined cycles, rsp_valid, rsp_err, mem_en and mem_we are 0. rsp_rdata holds its last value.
- Request rules:
  - A requester holds req_valid and payload stable until req_ready.
  - Dropping req_valid before ready is legal and creates no transaction.
  - req_valid sampled in non-IDLE states is ignored (no ready).
- Latency, idle request to rsp_valid:
  - Write: 2 cycles (IDLE→ACCESS→DONE).
  - Read: 2+READ_LATENCY cycles.
  - Error: 1 cycle.
- Fairness: with both ports continuously requesting, grants alternate strictly 0,1,0,1. A waiting port is served after at most one foreign transaction.
- No byte enables; only full DATA_W accesses. Alignment is not checked; the low address bits pass through.

Decomposition:
- Shared header (defs.h): FSM state encodings (2-bit), PORT_CPU=0 / PORT_HOST=1, DMEM_RSP_OK/DMEM_RSP_ERR, MEM_BYTES default.
- One sub-module: rr_arbiter2. Inputs: req[1:0], last_grant, en. Outputs: one-hot grant[1:0] and index g. Purely combinational.
- Top holds the FSM, payload registers, latency counter and grant counters.

Test Plan:
- Port 0 write addr=0x10 data=0xDEADBEEF, idle port 1 → req_ready[0] in cycle 0; mem_en=mem_we=1, mem_addr=0x10 in cycle 1; rsp_valid=2'b01, rsp_rdata=0 in cycle 2; grant_cnt0=1.
- READ_LATENCY=3, port 1 read addr=0x10, memory returns 0xDEADBEEF → rsp_valid=2'b10 exactly 5 cycles after request; rsp_rdata=0xDEADBEEF; mem_en high for exactly one cycle.
- Both ports hold valid for 4 transactions after reset → grant order 0,1,0,1; grant_cnt0=grant_cnt1=2; no cycle with both req_ready bits set.
- Port 0 read addr=MEM_BYTES (4096) → rsp_err=1 and rsp_valid[0] 1 cycle after accept; mem_en never asserted; rsp_rdata=0.
- Assert rst=0 in WAIT of a port-1 read → all outputs 0 immediately; after release, no stale rsp_valid; next tie granted to port 0.
- Port 1 drops req_valid while port 0 is in ACCESS → port 1 never gets req_ready or rsp_valid; busy returns to 0 after port 0's DONE.
